// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants for the ALU control sequencer.
//   - ALU control codes (4-bit, zero-extended by users to their control width)
//   - alu_op and R-type funct encodings
//   - HI/LO unit operation encoding
//   - sequencer FSM state type
package alu_ctrl_pkg;

  // ALU control codes
  localparam logic [3:0] CodeAnd  = 4'b0000;
  localparam logic [3:0] CodeOr   = 4'b0001;
  localparam logic [3:0] CodeAdd  = 4'b0010;
  localparam logic [3:0] CodeXor  = 4'b0011;
  localparam logic [3:0] CodeNor  = 4'b0100;
  localparam logic [3:0] CodeSll  = 4'b0101;
  localparam logic [3:0] CodeSub  = 4'b0110;
  localparam logic [3:0] CodeSlt  = 4'b0111;
  localparam logic [3:0] CodeSltu = 4'b1000;
  localparam logic [3:0] CodeSrl  = 4'b1001;
  localparam logic [3:0] CodeSra  = 4'b1010;
  localparam logic [3:0] CodeNop  = 4'b1111;

  // alu_op field from the main control decoder
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;
  localparam logic [1:0] AluOpSlt   = 2'b11;

  // R-type funct field
  localparam logic [5:0] FunctSll   = 6'h00;
  localparam logic [5:0] FunctSrl   = 6'h02;
  localparam logic [5:0] FunctSra   = 6'h03;
  localparam logic [5:0] FunctMfhi  = 6'h10;
  localparam logic [5:0] FunctMflo  = 6'h12;
  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1A;
  localparam logic [5:0] FunctDivu  = 6'h1B;
  localparam logic [5:0] FunctAdd   = 6'h20;
  localparam logic [5:0] FunctAddu  = 6'h21;
  localparam logic [5:0] FunctSub   = 6'h22;
  localparam logic [5:0] FunctSubu  = 6'h23;
  localparam logic [5:0] FunctAnd   = 6'h24;
  localparam logic [5:0] FunctOr    = 6'h25;
  localparam logic [5:0] FunctXor   = 6'h26;
  localparam logic [5:0] FunctNor   = 6'h27;
  localparam logic [5:0] FunctSlt   = 6'h2A;
  localparam logic [5:0] FunctSltu  = 6'h2B;

  // HI/LO unit operation
  localparam logic [1:0] MdMult  = 2'b00;
  localparam logic [1:0] MdMultu = 2'b01;
  localparam logic [1:0] MdDiv   = 2'b10;
  localparam logic [1:0] MdDivu  = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } seq_state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational {alu_op, funct} -> ALU control decode.
// Ports:
//   i_alu_op      alu_op from the main decoder
//   i_funct       R-type function field
//   o_code        4-bit ALU control code
//   o_illegal     unknown R-type funct (code forced to NOP)
//   o_is_md       mult/multu/div/divu
//   o_is_mfhilo   mfhi/mflo
//   o_md_op       HI/LO unit operation, meaningful only with o_is_md
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_code,
  output logic       o_illegal,
  output logic       o_is_md,
  output logic       o_is_mfhilo,
  output logic [1:0] o_md_op
);

  always_comb begin
    o_code      = CodeAdd;
    o_illegal   = 1'b0;
    o_is_md     = 1'b0;
    o_is_mfhilo = 1'b0;
    o_md_op     = MdMult;
    unique case (i_alu_op)
      AluOpAdd: o_code = CodeAdd;
      AluOpSub: o_code = CodeSub;
      AluOpSlt: o_code = CodeSlt;
      AluOpRtype: begin
        case (i_funct)
          FunctAdd, FunctAddu: o_code = CodeAdd;
          FunctSub, FunctSubu: o_code = CodeSub;
          FunctAnd:            o_code = CodeAnd;
          FunctOr:             o_code = CodeOr;
          FunctXor:            o_code = CodeXor;
          FunctNor:            o_code = CodeNor;
          FunctSlt:            o_code = CodeSlt;
          FunctSltu:           o_code = CodeSltu;
          FunctSll:            o_code = CodeSll;
          FunctSrl:            o_code = CodeSrl;
          FunctSra:            o_code = CodeSra;
          FunctMult, FunctMultu, FunctDiv, FunctDivu: begin
            // ALU idles while the HI/LO unit works; funct[1:0] is the md_op encoding
            o_code  = CodeNop;
            o_is_md = 1'b1;
            o_md_op = i_funct[1:0];
          end
          FunctMfhi, FunctMflo: begin
            // pass-through add; the datapath muxes HI or LO in
            o_code      = CodeAdd;
            o_is_mfhilo = 1'b1;
          end
          default: begin
            o_code    = CodeNop;
            o_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered ALU control decode with HI/LO unit sequencing.
// Ports:
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   in_valid       decode stage presents {alu_op, funct}
//   in_ready       op accepted when in_valid && in_ready
//   alu_op, funct  op to decode
//   out_valid      alu_control/illegal carry a newly accepted op this cycle
//   alu_control    registered ALU control code (CTRL_W bits)
//   illegal        registered: accepted op had an unknown R-type funct
//   md_start       one-cycle pulse launching the HI/LO unit
//   md_op          HI/LO operation, stable from md_start through md_done
//   md_busy        HI/LO unit occupied (exactly MD_CYCLES cycles per launch)
//   md_done        one-cycle pulse in the final busy cycle
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W    = 4,
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = $clog2(MD_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy,
  output logic              md_done
);

  logic [3:0] w_code;
  logic       w_illegal;
  logic       w_is_md;
  logic       w_is_mfhilo;
  logic [1:0] w_md_op;
  logic       w_hazard;
  logic       w_accept;

  seq_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_alu_control;
  logic              r_illegal;
  logic              r_md_start;
  logic [1:0]        r_md_op;
  logic              r_md_busy;
  logic              r_md_done;

  alu_funct_decode u_decode (
    .i_alu_op    (alu_op),
    .i_funct     (funct),
    .o_code      (w_code),
    .o_illegal   (w_illegal),
    .o_is_md     (w_is_md),
    .o_is_mfhilo (w_is_mfhilo),
    .o_md_op     (w_md_op)
  );

  // Only ops touching HI/LO wait for the unit; everything else flows past it.
  assign w_hazard = w_is_md | w_is_mfhilo;
  assign in_ready = rst_n & ((r_state == StIdle) | ~(in_valid & w_hazard));
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_out_valid   <= 1'b0;
      r_alu_control <= CTRL_W'(CodeAdd);
      r_illegal     <= 1'b0;
      r_md_start    <= 1'b0;
      r_md_op       <= MdMult;
      r_md_busy     <= 1'b0;
      r_md_done     <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      r_md_start  <= 1'b0;
      r_md_done   <= 1'b0;
      if (w_accept) begin
        r_alu_control <= CTRL_W'(w_code);
        r_illegal     <= w_illegal;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept && w_is_md) begin
            r_state    <= StBusy;
            r_md_start <= 1'b1;
            r_md_op    <= w_md_op;
            r_md_busy  <= 1'b1;
            r_cnt      <= CNT_W'(MD_CYCLES - 1);
          end
        end
        StBusy: begin
          if (r_cnt == '0) begin
            r_state   <= StIdle;
            r_md_busy <= 1'b0;
          end else begin
            r_cnt     <= r_cnt - CNT_W'(1);
            // registered pulse lands in the cycle where the count reads zero
            r_md_done <= (r_cnt == CNT_W'(1));
          end
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign alu_control = r_alu_control;
  assign illegal     = r_illegal;
  assign md_start    = r_md_start;
  assign md_op       = r_md_op;
  assign md_busy     = r_md_busy;
  assign md_done     = r_md_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int unsigned CtrlW    = 4;
  localparam int unsigned MdCycles = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [1:0]       alu_op = 2'b00;
  logic [5:0]       funct = 6'h00;
  logic             in_ready;
  logic             out_valid;
  logic [CtrlW-1:0] alu_control;
  logic             illegal;
  logic             md_start;
  logic [1:0]       md_op;
  logic             md_busy;
  logic             md_done;

  alu_op_sequencer #(
    .CTRL_W    (CtrlW),
    .MD_CYCLES (MdCycles)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .out_valid   (out_valid),
    .alu_control (alu_control),
    .illegal     (illegal),
    .md_start    (md_start),
    .md_op       (md_op),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic acc_q = 1'b0;

  // running totals sampled at each falling edge
  int start_tot = 0;
  int busy_tot = 0;
  int done_tot = 0;
  int last_done_busy = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) acc_q <= in_valid && in_ready;

  always @(negedge clk) begin
    if (md_start) start_tot++;
    if (md_busy) busy_tot++;
    if (md_done) begin
      done_tot++;
      last_done_busy = busy_tot;
    end
    if (mon_en) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, acc_q});
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected got=%0h exp=none @%0t", alu_control, $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("alu_control", 32'(alu_control), 32'(e.code));
          check("illegal", {31'b0, illegal}, {31'b0, e.ill});
        end
      end
    end
  end

  // Present an op and hold it until accepted; the expected result is queued
  // once the handshake is known to complete at the coming rising edge.
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [3:0] code,
                       input logic ill, output int stalls);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = op;
    funct    = f;
    stalls   = 0;
    #1;
    while (!in_ready && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout got=in_ready0 exp=in_ready1 @%0t", $time);
    end else begin
      e.code = code;
      e.ill  = ill;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (md_busy && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    check(name, {31'b0, md_busy}, 32'd0);
  endtask

  vec_t vecs[21];

  initial begin
    int st;
    int s0, b0, d0, g;

    vecs[0]  = '{2'b10, 6'h22, 4'b0110, 1'b0};
    vecs[1]  = '{2'b00, 6'h00, 4'b0010, 1'b0};
    vecs[2]  = '{2'b01, 6'h00, 4'b0110, 1'b0};
    vecs[3]  = '{2'b11, 6'h00, 4'b0111, 1'b0};
    vecs[4]  = '{2'b10, 6'h3F, 4'b1111, 1'b1};
    vecs[5]  = '{2'b10, 6'h20, 4'b0010, 1'b0};
    vecs[6]  = '{2'b10, 6'h21, 4'b0010, 1'b0};
    vecs[7]  = '{2'b10, 6'h23, 4'b0110, 1'b0};
    vecs[8]  = '{2'b10, 6'h24, 4'b0000, 1'b0};
    vecs[9]  = '{2'b10, 6'h25, 4'b0001, 1'b0};
    vecs[10] = '{2'b10, 6'h26, 4'b0011, 1'b0};
    vecs[11] = '{2'b10, 6'h27, 4'b0100, 1'b0};
    vecs[12] = '{2'b10, 6'h2A, 4'b0111, 1'b0};
    vecs[13] = '{2'b10, 6'h2B, 4'b1000, 1'b0};
    vecs[14] = '{2'b10, 6'h00, 4'b0101, 1'b0};
    vecs[15] = '{2'b10, 6'h02, 4'b1001, 1'b0};
    vecs[16] = '{2'b10, 6'h03, 4'b1010, 1'b0};
    vecs[17] = '{2'b10, 6'h01, 4'b1111, 1'b1};
    vecs[18] = '{2'b10, 6'h10, 4'b0010, 1'b0};
    vecs[19] = '{2'b10, 6'h12, 4'b0010, 1'b0};
    vecs[20] = '{2'b00, 6'h3F, 4'b0010, 1'b0};

    // Reset with a hazard op presented: in_ready must still be low.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    alu_op   = 2'b10;
    funct    = 6'h18;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_control", 32'(alu_control), 32'h2);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_md_start", {31'b0, md_start}, 32'd0);
    check("rst_md_op", {30'b0, md_op}, 32'd0);
    check("rst_md_busy", {31'b0, md_busy}, 32'd0);
    check("rst_md_done", {31'b0, md_done}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    mon_en   = 1'b1;

    // Back-to-back decode table
    for (int i = 0; i < 21; i++) begin
      issue(vecs[i].op, vecs[i].f, vecs[i].code, vecs[i].ill, st);
      check("table_stall", st, 32'd0);
    end
    idle();
    repeat (2) @(negedge clk);

    // mult then mflo: mflo waits out the whole busy window
    s0 = start_tot;
    b0 = busy_tot;
    d0 = done_tot;
    issue(2'b10, 6'h18, 4'b1111, 1'b0, st);
    check("mult_stall", st, 32'd0);
    issue(2'b10, 6'h12, 4'b0010, 1'b0, st);
    check("mflo_stalls", st, MdCycles);
    check("mflo_accept_busy", {31'b0, md_busy}, 32'd0);
    check("mult_md_op", {30'b0, md_op}, 32'd0);
    idle();
    repeat (3) @(negedge clk);
    #1;
    check("mult_starts", start_tot - s0, 32'd1);
    check("mult_busy_cycles", busy_tot - b0, MdCycles);
    check("mult_dones", done_tot - d0, 32'd1);
    check("mult_done_pos", last_done_busy - b0, MdCycles);

    // Non-hazard op flows during BUSY
    b0 = busy_tot;
    issue(2'b10, 6'h19, 4'b1111, 1'b0, st);
    issue(2'b10, 6'h20, 4'b0010, 1'b0, st);
    check("add_busy_stall", st, 32'd0);
    check("add_busy_md_busy", {31'b0, md_busy}, 32'd1);
    idle();
    #1;
    check("multu_md_op", {30'b0, md_op}, 32'd1);
    check("add_after_md_busy", {31'b0, md_busy}, 32'd1);
    wait_idle("multu_finish");
    check("multu_busy_cycles", busy_tot - b0, MdCycles);

    // Reset on the 10th busy cycle aborts without md_done
    repeat (2) @(negedge clk);
    b0 = busy_tot;
    issue(2'b10, 6'h1A, 4'b1111, 1'b0, st);
    idle();
    g = 0;
    #1;
    while ((busy_tot - b0) < 10 && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("abort_busy_count", busy_tot - b0, 32'd10);
    d0 = done_tot;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("abort_md_busy", {31'b0, md_busy}, 32'd0);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd0);
    check("abort_md_op", {30'b0, md_op}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_done", done_tot - d0, 32'd0);
    check("abort_stay_idle", {31'b0, md_busy}, 32'd0);

    // Fresh divu from IDLE
    s0 = start_tot;
    issue(2'b10, 6'h1B, 4'b1111, 1'b0, st);
    check("divu_stall", st, 32'd0);
    idle();
    #1;
    check("divu_md_start", {31'b0, md_start}, 32'd1);
    check("divu_md_op", {30'b0, md_op}, 32'd3);
    check("divu_md_busy", {31'b0, md_busy}, 32'd1);
    wait_idle("divu_finish");
    check("divu_starts", start_tot - s0, 32'd1);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised, registered successor to the combinational ALU control decode.
- Maps {alu_op, funct} to a CTRL_W-bit ALU control code one cycle after acceptance, with a valid/ready handshake toward the decode stage.
- Adds sequencing for iterative multiply/divide: launches the HI/LO unit, tracks its busy window with a counter and stalls only the dependent ops (mult/div/mfhi/mflo) while it runs.
- Sits between the main control decoder and the execute stage.

Parameters:
- CTRL_W, 4, ALU control width; must be ≥ 4.
- MD_CYCLES, 32, cycles a mult/div occupies the HI/LO unit; must be ≥ 2.
- CNT_W, $clog2(MD_CYCLES), busy-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  decode stage presents an op.
- in_ready  out  1  op accepted when in_valid && in_ready.
- alu_op  in  2  00 add (lw/sw/addi), 01 sub (beq), 10 R-type (use funct), 11 slt (slti).
- funct  in  6  R-type function field.
- out_valid  out  1  registered: alu_control/illegal valid this cycle.
- alu_control  out  CTRL_W  registered ALU operation code.
- illegal  out  1  registered: unknown R-type funct accepted.
- md_start  out  1  one-cycle pulse launching the HI/LO unit.
- md_op  out  2  00 mult, 01 multu, 10 div, 11 divu; held stable from md_start until md_done.
- md_busy  out  1  HI/LO unit occupied.
- md_done  out  1  one-cycle pulse in the final busy cycle.

Behaviour:
- Control codes, zero-extended to CTRL_W, live in the shared package: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SLL 0101, SUB 0110, SLT 0111, SLTU 1000, SRL 1001, SRA 1010, NOP 1111.
- alu_op mapping: 00 → ADD, 01 → SUB, 11 → SLT, 10 → decode funct.
- funct decode:
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
  - 0x2A SLT; 0x2B SLTU; 0x00 SLL; 0x02 SRL; 0x03 SRA.
  - 0x18/0x19/0x1A/0x1B: mult/multu/div/divu.
  - 0x10/0x12: mfhi/mflo.
  - Any other funct: NOP with illegal=1.
- Latency: an op accepted in cycle N appears in cycle N+1 with out_valid=1. out_valid=0 in cycles with no acceptance; alu_control holds its last value.
- Hazard ops: mult/div/mfhi/mflo (alu_op=10 only).
- in_ready = 1 in IDLE; in BUSY, in_ready = !(in_valid && hazard op). Non-hazard ops flow during BUSY.
- Mult/div result code: alu_control=NOP, out_valid=1.
- mfhi/mflo result code: alu_control=ADD, out_valid=1; the datapath selects HI/LO.
- FSM states: IDLE, BUSY.
  - IDLE, mult/div accepted → BUSY. md_start=1 and md_op latched on the next edge, together with out_valid. cnt loads MD_CYCLES-1 and md_busy=1.
  - BUSY: cnt decrements each cycle. At cnt==0, md_done=1, and the next state is IDLE with md_busy=0.
  - A hazard op stalled in the md_done cycle is accepted the cycle after. No same-cycle bypass.
  - Total md_busy high time: exactly MD_CYCLES cycles.
- Reset values (rst_n=0 at a clock edge):
  - state=IDLE, cnt=0, out_valid=0, alu_control=ADD, illegal=0.
  - md_start=0, md_op=00, md_busy=0, md_done=0.
  - in_ready is 0 during reset.
  - Reset mid-BUSY aborts the operation with no md_done pulse.
- in_valid=0 never changes state except the BUSY countdown.

Decomposition:
- Package alu_ctrl_pkg: control-code localparams, funct constants, alu_op constants, md_op encoding, FSM state enum.
- Sub-module alu_funct_decode: purely combinational {alu_op, funct} → {code, illegal, is_md, is_mfhilo, md_op}.
- The top level holds the handshake, registers, FSM and counter.

Test Plan:
- Reset, then alu_op=10 funct=0x22 accepted → next cycle out_valid=1, alu_control=0110, illegal=0.
- alu_op=00, 01 and 11 on consecutive cycles (in_valid held) → outputs 0010, 0110, 0111 on successive cycles.
- alu_op=10 funct=0x3F → alu_control=1111, illegal=1, out_valid=1.
- mult (0x18) accepted, then mflo presented immediately with MD_CYCLES=32:
  - md_start pulses once and md_busy is high for exactly 32 cycles.
  - md_done is high in the 32nd busy cycle.
  - in_ready is low for mflo throughout BUSY; mflo is accepted the cycle after md_done.
- During BUSY, an add (0x20) is presented → accepted immediately, alu_control=0010 next cycle, md_busy unaffected.
- rst_n=0 on the 10th BUSY cycle → next cycle md_busy=0, out_valid=0, no md_done; a new divu is accepted from IDLE with md_op=11.
